systolic_array_nxn: RTL and testbench

//  Parametrised NxN output-stationary systolic matrix multiplier, successor to the fixed 2x2 array.

---
 rtl/systolic_array_nxn_if.sv | 30 +++
 rtl/systolic_array_nxn.sv | 159 +++++++++++++++
 tb/tb_systolic_array_nxn.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_nxn_if.sv
// rtl/systolic_array_nxn_if.sv - operand beat / result handshake bundle for systolic_array_nxn
interface systolic_array_nxn_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int K_MAX = 255
);
  localparam int KW = $clog2(K_MAX + 1);

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*WIDTH-1:0]     in_west;
  logic [N*WIDTH-1:0]     in_north;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*N*WIDTH-1:0]   out;
  logic                   sat;
  logic                   busy;

  modport master (
    output start, k_len, in_valid, in_west, in_north, out_ready,
    input  in_ready, out_valid, out, sat, busy
  );

  modport slave (
    input  start, k_len, in_valid, in_west, in_north, out_ready,
    output in_ready, out_valid, out, sat, busy
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - NxN output-stationary systolic matmul, skewed injection, saturating fixed-point results
module systolic_array_nxn #(
  parameter int N          = 4,
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int K_MAX      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_array_nxn_if.slave  bus
);
  localparam int KW         = $clog2(K_MAX + 1);
  localparam int AW         = 2*WIDTH + KW;
  localparam int DW         = (N > 1) ? $clog2(2*N) : 1;
  localparam int DRAIN_LAST = (N > 1) ? 2*N - 3 : 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [1:0] AFTER_LOAD = (N == 1) ? DONE : DRAIN;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [1:0]    state;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] beat_cnt;
  logic [DW-1:0] drain_cnt;
  logic          clear;
  logic          shift;
  logic          done;

  assign clear = (state == IDLE) && bus.start;
  assign shift = ((state == LOAD) && bus.in_valid) || (state == DRAIN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          k_reg     <= bus.k_len;
          beat_cnt  <= '0;
          drain_cnt <= '0;
          state     <= (bus.k_len == '0) ? DONE : LOAD;
        end
        LOAD: if (bus.in_valid) begin
          beat_cnt <= beat_cnt + KW'(1);
          if (beat_cnt == k_reg - KW'(1))
            state <= AFTER_LOAD;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(DRAIN_LAST))
            state <= DONE;
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end

  // Zeros are injected while draining so late shifts only flush real operands.
  logic [WIDTH-1:0] inj_w [N];
  logic [WIDTH-1:0] inj_n [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inj_w[i] = (state == LOAD) ? bus.in_west[(N-i)*WIDTH-1 -: WIDTH]  : '0;
      inj_n[i] = (state == LOAD) ? bus.in_north[(N-i)*WIDTH-1 -: WIDTH] : '0;
    end
  end

  logic [WIDTH-1:0]       w_in [N][N];
  logic [WIDTH-1:0]       n_in [N][N];
  logic [N*N*WIDTH-1:0]   res_flat;
  logic [N*N-1:0]         sat_vec;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign w_in[0][0] = inj_w[0];
      assign n_in[0][0] = inj_n[0];
    end else begin : g_delay
      logic [WIDTH-1:0] w_sr [i];
      logic [WIDTH-1:0] n_sr [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
          for (int j = 0; j < i; j++) begin
            w_sr[j] <= '0;
            n_sr[j] <= '0;
          end
        end else if (shift) begin
          w_sr[0] <= inj_w[i];
          n_sr[0] <= inj_n[i];
          for (int j = 1; j < i; j++) begin
            w_sr[j] <= w_sr[j-1];
            n_sr[j] <= n_sr[j-1];
          end
        end
      end
      assign w_in[i][0] = w_sr[i-1];
      assign n_in[0][i] = n_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [2*WIDTH-1:0] prod;
      logic signed [AW-1:0]      acc;
      logic signed [AW-1:0]      acc_shr;
      logic                      ovf_hi;
      logic                      ovf_lo;

      assign prod = $signed(w_in[i][c]) * $signed(n_in[i][c]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     acc <= '0;
        else if (clear) acc <= '0;
        else if (shift) acc <= acc + AW'(prod);
      end

      if (c < N-1) begin : g_east
        logic [WIDTH-1:0] w_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)     w_q <= '0;
          else if (clear) w_q <= '0;
          else if (shift) w_q <= w_in[i][c];
        end
        assign w_in[i][c+1] = w_q;
      end

      if (i < N-1) begin : g_south
        logic [WIDTH-1:0] n_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)     n_q <= '0;
          else if (clear) n_q <= '0;
          else if (shift) n_q <= n_in[i][c];
        end
        assign n_in[i+1][c] = n_q;
      end

      assign acc_shr = acc >>> FRAC_WIDTH;
      assign ovf_hi  = acc_shr > SAT_MAX;
      assign ovf_lo  = acc_shr < SAT_MIN;
      assign sat_vec[i*N + c] = ovf_hi | ovf_lo;
      assign res_flat[(N*N - (i*N + c))*WIDTH-1 -: WIDTH] =
        ovf_hi ? SAT_MAX[WIDTH-1:0] : (ovf_lo ? SAT_MIN[WIDTH-1:0] : acc_shr[WIDTH-1:0]);
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = done;
  assign bus.out       = done ? res_flat : '0;
  assign bus.sat       = done & (|sat_vec);
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb/tb_systolic_array_nxn.sv - directed plus randomized tiles against a plain-arithmetic matmul model
module tb_systolic_array_nxn;
  localparam int N     = 2;
  localparam int W     = 16;
  localparam int F     = 8;
  localparam int K_MAX = 255;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int OW    = N*N*W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_nxn_if #(.N(N), .WIDTH(W), .K_MAX(K_MAX)) bus ();

  systolic_array_nxn #(.N(N), .WIDTH(W), .FRAC_WIDTH(F), .K_MAX(K_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] a_m [N][16];
  logic signed [W-1:0] b_m [16][N];
  logic [OW-1:0]       exp_out;
  logic                exp_sat;
  logic [OW-1:0]       last_out;
  logic                last_sat;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C = A*B with full-precision sums, then floor shift and clamp.
  task automatic model(input int k);
    longint acc;
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    exp_out = '0;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < N; c++) begin
        acc = 0;
        for (int j = 0; j < k; j++)
          acc += longint'(a_m[i][j]) * longint'(b_m[j][c]);
        r = acc >>> F;
        if (r > hi) begin r = hi; exp_sat = 1'b1; end
        else if (r < lo) begin r = lo; exp_sat = 1'b1; end
        exp_out[(N*N - (i*N + c))*W-1 -: W] = W'(r);
      end
    end
  endtask

  task automatic fill(input int k, input int range);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < k; j++) begin
        a_m[i][j] = W'(int'($urandom_range(2*range)) - range);
        b_m[j][i] = W'(int'($urandom_range(2*range)) - range);
      end
  endtask

  task automatic drive_beat(input int j);
    for (int i = 0; i < N; i++) begin
      bus.in_west[(N-i)*W-1 -: W]  = a_m[i][j];
      bus.in_north[(N-i)*W-1 -: W] = b_m[j][i];
    end
  endtask

  task automatic run_tile(input string tag, input int k, input int stall, input int hold);
    int cyc;
    logic [OW-1:0] held;
    model(k);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    chk({tag, " idle_ready"}, OW'(bus.in_ready), '0);
    step();
    bus.start = 1'b0;
    bus.k_len = KW'($urandom);
    chk({tag, " busy"}, OW'(bus.busy), OW'(1));
    for (int j = 0; j < k; j++) begin
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'b0;
        bus.in_west  = $urandom;
        bus.in_north = $urandom;
        chk({tag, " stall_ready"}, OW'(bus.in_ready), OW'(1));
        step();
      end
      chk({tag, " load_ready"}, OW'(bus.in_ready), OW'(1));
      bus.in_valid = 1'b1;
      drive_beat(j);
      step();
      bus.in_valid = 1'b0;
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 64) begin
      bus.in_valid = 1'b1;
      bus.in_west  = $urandom;
      bus.in_north = $urandom;
      chk({tag, " drain_ready"}, OW'(bus.in_ready), '0);
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, OW'(cyc), OW'((k == 0) ? 0 : 2*N - 2));
    held = bus.out;
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.start = h[0];
      step();
      chk({tag, " hold_valid"}, OW'(bus.out_valid), OW'(1));
      chk({tag, " hold_out"}, bus.out, held);
    end
    bus.start = 1'b0;
    last_out = bus.out;
    last_sat = bus.sat;
    chk({tag, " out"}, bus.out, exp_out);
    chk({tag, " sat"}, OW'(bus.sat), OW'(exp_sat));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, " valid_drop"}, OW'(bus.out_valid), '0);
    chk({tag, " idle"}, OW'(bus.busy), '0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.in_west   = '0;
    bus.in_north  = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("reset out_valid", OW'(bus.out_valid), '0);
    chk("reset in_ready", OW'(bus.in_ready), '0);
    chk("reset busy", OW'(bus.busy), '0);
    chk("reset out", bus.out, '0);
    chk("reset sat", OW'(bus.sat), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    a_m[0][0] = 16'h0100; a_m[0][1] = 16'h0200;
    a_m[1][0] = 16'h0300; a_m[1][1] = 16'h0400;
    b_m[0][0] = 16'h0500; b_m[0][1] = 16'h0600;
    b_m[1][0] = 16'h0700; b_m[1][1] = 16'h0800;
    run_tile("basic", 2, 0, 0);
    chk("basic known", last_out, 64'h1300_1600_2B00_3200);
    run_tile("stall", 2, 3, 0);
    chk("stall known", last_out, 64'h1300_1600_2B00_3200);

    a_m[0][0] = 16'h7F00; a_m[1][0] = 16'h0000;
    b_m[0][0] = 16'h7F00; b_m[0][1] = 16'h8100;
    run_tile("satur", 1, 0, 0);
    chk("satur known", last_out, 64'h7FFF_8000_0000_0000);
    chk("satur flag", OW'(last_sat), OW'(1));

    run_tile("k0", 0, 0, 0);
    chk("k0 known", last_out, '0);

    fill(3, 16'h0400);
    run_tile("backpr", 3, 1, 5);

    for (int r = 0; r < 6; r++) begin
      int k;
      k = int'($urandom_range(1, 6));
      fill(k, (r == 5) ? 32768 : 16'h0800);
      run_tile("rand", k, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    fill(3, 16'h0400);
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    step();
    bus.start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      drive_beat(j);
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", OW'(bus.busy), '0);
    chk("rst in_ready", OW'(bus.in_ready), '0);
    chk("rst out_valid", OW'(bus.out_valid), '0);
    chk("rst out", bus.out, '0);
    chk("rst sat", OW'(bus.sat), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    a_m[0][0] = 16'h0100; a_m[0][1] = 16'h0000;
    a_m[1][0] = 16'h0000; a_m[1][1] = 16'h0100;
    b_m[0][0] = 16'h0100; b_m[0][1] = 16'h0000;
    b_m[1][0] = 16'h0000; b_m[1][1] = 16'h0100;
    run_tile("ident", 2, 0, 0);
    chk("ident known", last_out, 64'h0100_0000_0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
